halfadder_bist: RTL
===================

# halfadder_bist

Synthesizable built-in self-test controller for the `hafladder` half adder. It drives all four input patterns into the adder, waits a programmable settle time, and compares the adder's sum/carry outputs against a golden model. It reports a per-pattern fail vector and a pass flag. It sits beside the adder in hardware and performs the same sequence the simulation bench performs, so the adder can be checked on silicon/FPGA without a simulator.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 1: cycles between driving a pattern and sampling the response; legal range 1..255.

Ports:
- `i_clk`  in  1  clock; all logic on its rising edge.
- `i_rst`  in  1  reset; asynchronous, active-high.
- `i_start`  in  1  begin a test run; sampled only in IDLE.
- `i_abort`  in  1  cancel a run in progress; return to IDLE without `o_done`.
- `o_p0`  out  1  drives adder input p0 (pattern bit 0).
- `o_p1`  out  1  drives adder input p1 (pattern bit 1).
- `i_sum`  in  1  adder sum output (adder o_p0).
- `i_carry`  in  1  adder carry output (adder o_p1).
- `o_busy`  out  1  high in every state except IDLE.
- `o_done`  out  1  one-cycle pulse at the end of a completed run.
- `o_pass`  out  1  1 when the last completed run had zero mismatches; held until the next start.
- `o_fail_vec`  out  4  bit k set when pattern k mismatched; held until the next start.

## Operation
- Pattern k (0..3) drives `o_p0 = k[0]`, `o_p1 = k[1]`.
- Expected response: sum = p0 ^ p1, carry = p0 & p1.
- FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE → DRIVE when `i_start` = 1. On that edge: pattern index ← 0, `o_fail_vec` ← 0, `o_pass` ← 0.
- DRIVE (1 cycle): register `o_p0`/`o_p1` from the pattern index; load the settle counter with `SETTLE_CYCLES`; go to SETTLE.
- SETTLE (exactly `SETTLE_CYCLES` cycles): decrement the counter; go to CHECK when it expires.
- CHECK (1 cycle):
  - Sample `i_sum`/`i_carry` and compare both bits; on any mismatch set `o_fail_vec[k]`.
  - If k = 3, go to DONE; else k ← k+1 and go to DRIVE.
- DONE (1 cycle): `o_done` = 1; `o_pass` ← (final fail vector == 0), where the final vector includes the pattern-3 result; go to IDLE.
- `i_start` outside IDLE is ignored, including in DONE.
- `i_abort` in any non-IDLE state forces IDLE on the next edge:
  - No `o_done`.
  - `o_pass` stays 0.
  - `o_fail_vec` keeps its partial value.
  - Abort in CHECK wins: that pattern's result is discarded.
- `i_abort` in IDLE has no effect. `i_abort` and `i_start` together in IDLE: start wins.
- `o_p0`/`o_p1` keep the last pattern after a run or abort; they clear only on reset.

## Timing
- Reset values: state IDLE; `o_p0`=0, `o_p1`=0, `o_busy`=0, `o_done`=0, `o_pass`=0, `o_fail_vec`=4'b0000; pattern index 0; settle counter 0.
- Each pattern occupies N+2 cycles, with N = `SETTLE_CYCLES`.
- With `i_start` sampled at edge 0:
  - Pattern 0 appears on `o_p0`/`o_p1` after edge 1.
  - `o_busy` rises after edge 0.
  - `o_done` is high during the cycle after edge 4(N+2)+1, i.e. 13 cycles after start for N=1.
  - `o_busy` falls after the next edge.
- `o_pass` and `o_fail_vec` are final no later than the cycle in which `o_done` is high.
- Reset mid-run: immediate return to reset values; no `o_done`.
- Back-to-back runs: `i_start` high in the cycle after DONE (state IDLE) starts a new run.

## Structure
- Package `halfadder_pkg` holds:
  - the FSM state enum;
  - `NUM_PATTERNS` = 4;
  - the settle-counter width (8);
  - the expected-value function (sum/carry of two bits).
- One sub-module, `halfadder_ref`: a combinational golden model (two bits in, sum/carry out), instantiated once in the checker.
- The counter and FSM stay in `halfadder_bist`.

## Test plan
- Correct `hafladder` connected, N=1, pulse `i_start` → `o_done` pulse 13 cycles later, `o_pass`=1, `o_fail_vec`=4'b0000; `o_p1`/`o_p0` sequence 00, 01, 10, 11.
- Faulty adder with carry stuck at 0 → `o_pass`=0, `o_fail_vec`=4'b1000.
- Faulty adder with sum stuck at 1 → `o_fail_vec`=4'b1001, `o_pass`=0.
- `i_start` re-pulsed during SETTLE of pattern 2 → ignored; single `o_done`; results unchanged.
- `i_abort` asserted in CHECK of pattern 1 with a stuck-carry DUT → IDLE next cycle, no `o_done`, `o_fail_vec`=4'b0000.
- `i_rst` asserted mid-run → all outputs at reset values immediately. Then run with N=3 → `o_done` 21 cycles after start, `o_pass`=1.

Source files
------------

// File: rtl/halfadder_pkg.sv
// Shared definitions for the half-adder built-in self-test.
// Contents: FSM state encoding, pattern count, settle-counter width and the
// golden half-adder function used by the reference model.
package halfadder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } bist_state_e;

    localparam int unsigned NUM_PATTERNS = 4;
    localparam int unsigned PAT_W        = 2;
    localparam int unsigned CNT_W        = 8;

    // Golden half-adder: returns {carry, sum} of two bits.
    function automatic logic [1:0] ha_expected(input logic a, input logic b);
        ha_expected = {a & b, a ^ b};
    endfunction

endpackage

// File: rtl/halfadder_ref.sv
// Combinational golden model of a half adder.
// Ports:
//   a_i, b_i  : operand bits (the pattern currently driven)
//   sum_o     : expected sum   (a ^ b)
//   carry_o   : expected carry (a & b)
module halfadder_ref
    import halfadder_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic carry_o
);

    assign {carry_o, sum_o} = ha_expected(a_i, b_i);

endmodule

// File: rtl/halfadder_bist.sv
// Built-in self-test controller for a half adder. Drives the four input
// patterns, waits SETTLE_CYCLES, compares the adder response against the
// golden model and reports a per-pattern fail vector plus a pass flag.
// Ports:
//   i_clk, i_rst      : clock, asynchronous active-high reset
//   i_start           : begin a run (only honoured in IDLE)
//   i_abort           : cancel a run in progress
//   o_p0, o_p1        : pattern bits driven into the adder
//   i_sum, i_carry    : adder response
//   o_busy            : high whenever the controller is not idle
//   o_done            : one-cycle pulse after a completed run
//   o_pass            : last completed run had no mismatch
//   o_fail_vec        : bit k set when pattern k mismatched
module halfadder_bist
    import halfadder_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_abort,
    output logic       o_p0,
    output logic       o_p1,
    input  logic       i_sum,
    input  logic       i_carry,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic [3:0] o_fail_vec
);

    localparam logic [PAT_W-1:0] LAST_PAT    = PAT_W'(NUM_PATTERNS - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

    bist_state_e       state_q;
    logic [PAT_W-1:0]  idx_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              p0_q;
    logic              p1_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [3:0]        fail_vec_q;

    logic              exp_sum_s;
    logic              exp_carry_s;
    logic              mismatch_s;

    // Golden response for the pattern currently held on the adder inputs.
    halfadder_ref u_ref (
        .a_i     (p0_q),
        .b_i     (p1_q),
        .sum_o   (exp_sum_s),
        .carry_o (exp_carry_s)
    );

    // Response compare: either output bit wrong counts as a mismatch.
    always_comb begin
        mismatch_s = 1'b0;
        if ((i_sum != exp_sum_s) || (i_carry != exp_carry_s)) begin
            mismatch_s = 1'b1;
        end else begin
            mismatch_s = 1'b0;
        end
    end

    // Test sequencer with registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            p0_q       <= 1'b0;
            p1_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_vec_q <= 4'b0000;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Abort is meaningless here; start always wins.
                    if (i_start) begin
                        state_q    <= ST_DRIVE;
                        idx_q      <= '0;
                        fail_vec_q <= 4'b0000;
                        pass_q     <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (i_abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        p0_q    <= idx_q[0];
                        p1_q    <= idx_q[1];
                        cnt_q   <= SETTLE_LOAD;
                        state_q <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (i_abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        // Leaving on count 1 gives exactly SETTLE_CYCLES cycles here.
                        if (cnt_q <= CNT_W'(1)) begin
                            state_q <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    // An abort here drops this pattern's result entirely.
                    if (i_abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        if (mismatch_s) begin
                            fail_vec_q[idx_q] <= 1'b1;
                        end
                        if (idx_q == LAST_PAT) begin
                            state_q <= ST_DONE;
                        end else begin
                            idx_q   <= idx_q + PAT_W'(1);
                            state_q <= ST_DRIVE;
                        end
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                    if (!i_abort) begin
                        done_q <= 1'b1;
                        pass_q <= (fail_vec_q == 4'b0000);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_p0       = p0_q;
    assign o_p1       = p1_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_pass     = pass_q;
    assign o_fail_vec = fail_vec_q;

endmodule
